tv80_blkxfer: RTL and testbench

- Block-transfer sequencer for the TV80 core. It executes LDI/LDD/LDIR/LDDR-style moves against the 8x16 register file and a simple memory handshake.
- Sits directly upstream of the register file. It drives the file's port-A address, write data and write enables, and consumes the port-A read data.
- Holds BC/DE/HL in local copies during a transfer. Writes the updated pairs back after every byte moved.

---
 rtl/tv80_blkxfer.sv | 181 ++++++++++++++++++
 tb/tb_tv80_blkxfer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tv80_blkxfer.sv
`default_nettype none
// ============================================================================
// Module   : tv80_blkxfer
// Function : LDI/LDD/LDIR/LDDR block-transfer sequencer for the TV80 core
// Revision : 1.0
// ============================================================================
module tv80_blkxfer #(
   parameter int BC_IDX = 0,
   parameter int DE_IDX = 1,
   parameter int HL_IDX = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        CEN,
   input  logic        start,
   input  logic        dec,
   input  logic        rpt,
   input  logic        alt_sel,
   output logic [2:0]  AddrA,
   output logic [7:0]  DIH,
   output logic [7:0]  DIL,
   output logic        WEH,
   output logic        WEL,
   input  logic [7:0]  DOAH,
   input  logic [7:0]  DOAL,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic        pv
);

   localparam logic [1:0] BC_SEL = 2'(BC_IDX);
   localparam logic [1:0] DE_SEL = 2'(DE_IDX);
   localparam logic [1:0] HL_SEL = 2'(HL_IDX);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_RD_BC = 4'd1,
      S_RD_DE = 4'd2,
      S_RD_HL = 4'd3,
      S_MRD   = 4'd4,
      S_MWR   = 4'd5,
      S_WB_HL = 4'd6,
      S_WB_DE = 4'd7,
      S_WB_BC = 4'd8,
      S_FIN   = 4'd9
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] bc_q, bc_d, de_q, de_d, hl_q, hl_d;
   logic [7:0]  data_q, data_d;
   logic        dec_q, dec_d, rpt_q, rpt_d, alt_q, alt_d, pv_q, pv_d;
   logic        we;

   logic [15:0] hl_step, de_step, bc_dec;

   assign hl_step = dec_q ? (hl_q - 16'd1) : (hl_q + 16'd1);
   assign de_step = dec_q ? (de_q - 16'd1) : (de_q + 16'd1);
   assign bc_dec  = bc_q - 16'd1;

   always_comb begin
      state_d   = state_q;
      bc_d      = bc_q;
      de_d      = de_q;
      hl_d      = hl_q;
      data_d    = data_q;
      dec_d     = dec_q;
      rpt_d     = rpt_q;
      alt_d     = alt_q;
      pv_d      = pv_q;
      we        = 1'b0;
      AddrA     = 3'd0;
      DIH       = 8'd0;
      DIL       = 8'd0;
      mem_addr  = 16'd0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wdata = 8'd0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dec_d   = dec;
               rpt_d   = rpt;
               alt_d   = alt_sel;
               state_d = S_RD_BC;
            end
         end
         S_RD_BC: begin
            AddrA   = {alt_q, BC_SEL};
            bc_d    = {DOAH, DOAL};
            state_d = S_RD_DE;
         end
         S_RD_DE: begin
            AddrA   = {alt_q, DE_SEL};
            de_d    = {DOAH, DOAL};
            state_d = S_RD_HL;
         end
         S_RD_HL: begin
            AddrA   = {alt_q, HL_SEL};
            hl_d    = {DOAH, DOAL};
            state_d = S_MRD;
         end
         S_MRD: begin
            mem_rd   = 1'b1;
            mem_addr = hl_q;
            if (mem_ack) begin
               data_d  = mem_rdata;
               state_d = S_MWR;
            end
         end
         S_MWR: begin
            mem_wr    = 1'b1;
            mem_addr  = de_q;
            mem_wdata = data_q;
            if (mem_ack) state_d = S_WB_HL;
         end
         S_WB_HL: begin
            AddrA      = {alt_q, HL_SEL};
            {DIH, DIL} = hl_step;
            we         = 1'b1;
            hl_d       = hl_step;
            state_d    = S_WB_DE;
         end
         S_WB_DE: begin
            AddrA      = {alt_q, DE_SEL};
            {DIH, DIL} = de_step;
            we         = 1'b1;
            de_d       = de_step;
            state_d    = S_WB_BC;
         end
         S_WB_BC: begin
            AddrA      = {alt_q, BC_SEL};
            {DIH, DIL} = bc_dec;
            we         = 1'b1;
            bc_d       = bc_dec;
            pv_d       = |bc_dec;
            state_d    = (rpt_q && (|bc_dec)) ? S_MRD : S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Reset suppresses the strobe so an interrupted writeback never lands.
   assign WEH  = we & CEN & ~reset;
   assign WEL  = we & CEN & ~reset;
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_FIN);
   assign pv   = pv_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         bc_q    <= 16'd0;
         de_q    <= 16'd0;
         hl_q    <= 16'd0;
         data_q  <= 8'd0;
         dec_q   <= 1'b0;
         rpt_q   <= 1'b0;
         alt_q   <= 1'b0;
         pv_q    <= 1'b0;
      end else if (CEN) begin
         state_q <= state_d;
         bc_q    <= bc_d;
         de_q    <= de_d;
         hl_q    <= hl_d;
         data_q  <= data_d;
         dec_q   <= dec_d;
         rpt_q   <= rpt_d;
         alt_q   <= alt_d;
         pv_q    <= pv_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tv80_blkxfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tv80_blkxfer
// Function : directed scoreboard bench for the block-transfer sequencer
// Revision : 1.0
// ============================================================================
module tb_tv80_blkxfer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        CEN = 1'b1;
   logic        start = 1'b0;
   logic        dec = 1'b0;
   logic        rpt = 1'b0;
   logic        alt_sel = 1'b0;
   logic [2:0]  AddrA;
   logic [7:0]  DIH, DIL;
   logic        WEH, WEL;
   logic [7:0]  DOAH, DOAL;
   logic [15:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        busy, done, pv;

   logic [15:0] rf [0:7];
   logic [7:0]  mem [0:65535];
   logic [23:0] sb_q [$];

   logic        rf_set = 1'b0;
   logic [2:0]  rf_set_idx = 3'd0;
   logic [15:0] rf_set_val = 16'd0;
   logic        mem_set = 1'b0;
   logic [15:0] mem_set_addr = 16'd0;
   logic [7:0]  mem_set_val = 8'd0;

   int n_assert = 0;
   int n_fail = 0;
   int cnt = 0;
   int rd_wait = 0;
   int wr_wait = 0;

   tv80_blkxfer dut (
      .clk(clk), .reset(reset), .CEN(CEN), .start(start), .dec(dec), .rpt(rpt),
      .alt_sel(alt_sel), .AddrA(AddrA), .DIH(DIH), .DIL(DIL), .WEH(WEH), .WEL(WEL),
      .DOAH(DOAH), .DOAL(DOAL), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy), .done(done), .pv(pv)
   );

   always #5 clk = ~clk;

   assign DOAH      = rf[AddrA][15:8];
   assign DOAL      = rf[AddrA][7:0];
   assign mem_rdata = mem[mem_addr];

   always_comb begin
      mem_ack = 1'b0;
      if (mem_rd)      mem_ack = (cnt >= rd_wait);
      else if (mem_wr) mem_ack = (cnt >= wr_wait);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Register file, memory and scoreboard consumer.
   always @(posedge clk) begin
      if (reset)                cnt <= 0;
      else if (mem_ack && CEN)  cnt <= 0;
      else if (mem_rd || mem_wr) cnt <= cnt + 1;
      else                      cnt <= 0;
      if (rf_set) rf[rf_set_idx] <= rf_set_val;
      if (WEH) rf[AddrA][15:8] <= DIH;
      if (WEL) rf[AddrA][7:0]  <= DIL;
      if (mem_set) mem[mem_set_addr] <= mem_set_val;
      if (!reset && CEN && mem_wr && mem_ack) begin
         mem[mem_addr] <= mem_wdata;
         chk("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0)
            chk("mem_write", {8'h0, mem_addr, mem_wdata}, {8'h0, sb_q.pop_front()});
      end
   end

   task automatic set_rf(input logic [2:0] i, input logic [15:0] v);
      rf_set = 1'b1; rf_set_idx = i; rf_set_val = v;
      @(posedge clk); #1;
      rf_set = 1'b0;
   endtask

   task automatic set_mem(input logic [15:0] a, input logic [7:0] v);
      mem_set = 1'b1; mem_set_addr = a; mem_set_val = v;
      @(posedge clk); #1;
      mem_set = 1'b0;
   endtask

   task automatic run(input bit d, input bit r, input bit a, input bit tog, input bit rst_wbde,
                      input int exp_done, input int exp_rd, input int exp_wr);
      int cyc = 0, done_at = -1, done_cnt = 0, rd_c = 0, wr_c = 0;
      bit fin = 0, prev_done = 0;
      dec = d; rpt = r; alt_sel = a; CEN = 1'b1; start = 1'b1;
      while (!fin) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) start = 1'b0;
         CEN = tog ? ~CEN : 1'b1;
         #1;
         if (!CEN) chk("we_low_when_cen_low", {30'd0, WEH, WEL}, 32'd0);
         if (WEH)  chk("alt_index", {31'd0, AddrA[2]}, {31'd0, a});
         if (mem_rd) rd_c++;
         if (mem_wr) wr_c++;
         if (done && done_at < 0) done_at = cyc;
         if (done && !prev_done) done_cnt++;
         prev_done = done;
         if (rst_wbde && WEH && AddrA[1:0] == 2'd1) begin
            reset = 1'b1;
            @(posedge clk); #2;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_we", {30'd0, WEH, WEL}, 32'd0);
            chk("rst_mem_req", {30'd0, mem_rd, mem_wr}, 32'd0);
            chk("rst_outputs", {AddrA, DIH, DIL, done, pv}, 32'd0);
            reset = 1'b0;
            fin = 1;
         end else if (done_at >= 0 && !busy) begin
            fin = 1;
         end
         if (!fin && cyc > 3000) begin
            chk("timeout_busy", {31'd0, busy}, 32'd0);
            fin = 1;
         end
      end
      CEN = 1'b1; start = 1'b0;
      if (!rst_wbde) chk("done_pulses", done_cnt, 1);
      if (exp_done > 0) chk("done_latency", done_at, exp_done);
      if (exp_rd > 0)   chk("mem_rd_cycles", rd_c, exp_rd);
      if (exp_wr > 0)   chk("mem_wr_cycles", wr_c, exp_wr);
   endtask

   logic [15:0] save0, save1, save2;

   initial begin
      for (int i = 0; i < 8; i++) begin
         rf_set = 1'b1; rf_set_idx = 3'(i); rf_set_val = 16'h0;
         @(posedge clk); #1;
      end
      rf_set = 1'b0;
      #1;
      chk("reset_busy_done_pv", {29'd0, busy, done, pv}, 32'd0);
      chk("reset_regfile_port", {AddrA, DIH, DIL, WEH, WEL}, 32'd0);
      chk("reset_mem_port", {mem_rd, mem_wr, mem_addr, mem_wdata}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // LDI
      set_rf(3'd0, 16'h0003); set_rf(3'd1, 16'h2000); set_rf(3'd2, 16'h1000);
      set_mem(16'h1000, 8'hA5);
      sb_q.push_back({16'h2000, 8'hA5});
      run(0, 0, 0, 0, 0, 9, 0, 0);
      chk("ldi_hl", rf[2], 16'h1001);
      chk("ldi_de", rf[1], 16'h2001);
      chk("ldi_bc", rf[0], 16'h0002);
      chk("ldi_pv", {31'd0, pv}, 32'd1);
      chk("ldi_mem", mem[16'h2000], 8'hA5);

      // LDDR
      set_rf(3'd0, 16'h0003); set_rf(3'd1, 16'h2002); set_rf(3'd2, 16'h1002);
      set_mem(16'h1000, 8'h11); set_mem(16'h1001, 8'h22); set_mem(16'h1002, 8'h33);
      sb_q.push_back({16'h2002, 8'h33});
      sb_q.push_back({16'h2001, 8'h22});
      sb_q.push_back({16'h2000, 8'h11});
      run(1, 1, 0, 0, 0, 0, 0, 0);
      chk("lddr_hl", rf[2], 16'h0FFF);
      chk("lddr_de", rf[1], 16'h1FFF);
      chk("lddr_bc", rf[0], 16'h0000);
      chk("lddr_pv", {31'd0, pv}, 32'd0);
      chk("lddr_mem", mem[16'h2000], 8'h11);

      // 16-bit wrap on all three pairs
      set_rf(3'd0, 16'h0000); set_rf(3'd1, 16'hFFFF); set_rf(3'd2, 16'hFFFF);
      set_mem(16'hFFFF, 8'h3C);
      sb_q.push_back({16'hFFFF, 8'h3C});
      run(0, 0, 0, 0, 0, 9, 0, 0);
      chk("wrap_hl", rf[2], 16'h0000);
      chk("wrap_de", rf[1], 16'h0000);
      chk("wrap_bc", rf[0], 16'hFFFF);
      chk("wrap_pv", {31'd0, pv}, 32'd1);

      // Memory wait states
      rd_wait = 3; wr_wait = 2;
      set_rf(3'd0, 16'h0001); set_rf(3'd1, 16'h6000); set_rf(3'd2, 16'h5000);
      set_mem(16'h5000, 8'h5A);
      sb_q.push_back({16'h6000, 8'h5A});
      run(0, 0, 0, 0, 0, 14, 4, 3);
      rd_wait = 0; wr_wait = 0;
      chk("wait_hl", rf[2], 16'h5001);
      chk("wait_de", rf[1], 16'h6001);
      chk("wait_bc", rf[0], 16'h0000);
      chk("wait_pv", {31'd0, pv}, 32'd0);

      // Alternate set with CEN toggling
      set_rf(3'd4, 16'h0002); set_rf(3'd5, 16'h7000); set_rf(3'd6, 16'h7100);
      set_mem(16'h7100, 8'hC3); set_mem(16'h7101, 8'h3C);
      save0 = rf[0]; save1 = rf[1]; save2 = rf[2];
      sb_q.push_back({16'h7000, 8'hC3});
      sb_q.push_back({16'h7001, 8'h3C});
      run(0, 1, 1, 1, 0, 0, 0, 0);
      chk("alt_hl", rf[6], 16'h7102);
      chk("alt_de", rf[5], 16'h7002);
      chk("alt_bc", rf[4], 16'h0000);
      chk("alt_pv", {31'd0, pv}, 32'd0);
      chk("alt_main_untouched", {rf[0], rf[1], rf[2]} == {save0, save1, save2}, 1);
      chk("alt_mem", mem[16'h7001], 8'h3C);

      // Reset during WB_DE of an LDIR, then a normal LDI
      set_rf(3'd0, 16'h0003); set_rf(3'd1, 16'h4000); set_rf(3'd2, 16'h3000);
      set_mem(16'h3000, 8'h77); set_mem(16'h3001, 8'h88);
      sb_q.push_back({16'h4000, 8'h77});
      run(0, 1, 0, 0, 1, 0, 0, 0);
      chk("rst_hl_written", rf[2], 16'h3001);
      chk("rst_de_kept", rf[1], 16'h4000);
      chk("rst_bc_kept", rf[0], 16'h0003);
      chk("rst_mem", mem[16'h4000], 8'h77);
      sb_q.push_back({16'h4000, 8'h88});
      run(0, 0, 0, 0, 0, 9, 0, 0);
      chk("post_hl", rf[2], 16'h3002);
      chk("post_de", rf[1], 16'h4001);
      chk("post_bc", rf[0], 16'h0002);
      chk("post_pv", {31'd0, pv}, 32'd1);
      chk("post_mem", mem[16'h4000], 8'h88);

      chk("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
